// File: rtl/object_buffer_pkg.sv
// Shared definitions for the fetch / object buffer / serializer pipeline.
// Holds the decoded table-entry record and the protobuf wire-type codes.
package pb_pkg;

    localparam int unsigned TABLE_ENTRY_W = 128;

    typedef enum logic [2:0] {
        WT_VARINT = 3'd0,
        WT_I64    = 3'd1,
        WT_LEN    = 3'd2,
        WT_SGROUP = 3'd3,
        WT_EGROUP = 3'd4,
        WT_I32    = 3'd5
    } wire_type_e;

    typedef struct packed {
        logic [28:0] field_id;
        logic [2:0]  wire_type;
        logic [31:0] field_offset;
        logic [63:0] nested_addr;
    } TABLE_ENTRY;

endpackage

// File: rtl/object_buffer_if.sv
// Push (fetch side), pop (serializer side) and status signals of the object buffer.
// The slave modport is the buffer; master is whatever drives it.
interface object_buffer_if #(
    parameter int unsigned DEPTH = 8
);
    import pb_pkg::*;

    logic                         ob_valid;
    TABLE_ENTRY                   entry;
    logic                         ob_full;
    logic                         ob_almost_full;
    logic                         out_valid;
    TABLE_ENTRY                   out_entry;
    logic                         out_ready;
    logic                         flush;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;

    modport master (
        output ob_valid, entry, out_ready, flush,
        input  ob_full, ob_almost_full, out_valid, out_entry, count, overflow
    );

    modport slave (
        input  ob_valid, entry, out_ready, flush,
        output ob_full, ob_almost_full, out_valid, out_entry, count, overflow
    );

endinterface

// File: rtl/object_buffer.sv
// First-word-fall-through FIFO of TABLE_ENTRY records between fetch and serializer.
// Flags are registered from next-count; overflow is sticky until reset or flush.
module object_buffer
    import pb_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic            clk,
    input  logic            reset,
    object_buffer_if.slave  bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ob_full_q, ob_full_d;
    logic          ob_af_q, ob_af_d;
    logic          overflow_q, overflow_d;
    TABLE_ENTRY    mem_q [DEPTH];
    TABLE_ENTRY    mem_d [DEPTH];

    logic out_valid;
    logic push;
    logic pop;

    assign out_valid = (count_q != '0);
    // Acceptance uses the registered full flag, so a pop from full never frees a slot same-cycle.
    assign push = bus.ob_valid && !ob_full_q && !bus.flush;
    assign pop  = out_valid && bus.out_ready && !bus.flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (bus.ob_valid && ob_full_q) overflow_d = 1'b1;
        end
        ob_full_d = (count_d == CW'(DEPTH));
        ob_af_d   = (count_d >= CW'(AF_LEVEL));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ob_full_q  <= 1'b0;
            ob_af_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ob_full_q  <= ob_full_d;
            ob_af_q    <= ob_af_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = bus.entry;
    end

    // Storage contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.ob_full        = ob_full_q;
    assign bus.ob_almost_full = ob_af_q;
    assign bus.out_valid      = out_valid;
    assign bus.out_entry      = mem_q[rd_ptr_q];
    assign bus.count          = count_q;
    assign bus.overflow       = overflow_q;

endmodule
